// File: rtl/ramfifo_ctrl_gen2.sv
// Pointer, occupancy and flag control for an external DEPTH-entry RAM FIFO.
// Addresses come from a binary counter or a full-period (zero-inclusive) LFSR.
module ramfifo_ctrl_gen2 #(
  parameter int LOG_DEP   = 6,
  parameter int ADDR_MODE = 1,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               flush,
  input  logic               write,
  input  logic               read,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [LOG_DEP:0]   count,
  output logic               overflow,
  output logic               underflow,
  output logic               ram_wen,
  output logic [LOG_DEP-1:0] ram_waddr,
  output logic [LOG_DEP-1:0] ram_raddr,
  output logic [LOG_DEP-1:0] ram_raddr_next
);

  localparam int DEPTH = 1 << LOG_DEP;
  localparam logic [LOG_DEP:0] DEPTH_CNT = (LOG_DEP+1)'(DEPTH);
  localparam logic [LOG_DEP:0] AF_LEVEL  = (LOG_DEP+1)'(DEPTH - AF_MARGIN);
  localparam logic [LOG_DEP:0] AE_LEVEL  = (LOG_DEP+1)'(AE_MARGIN);
  localparam logic [LOG_DEP:0] CNT_ONE   = (LOG_DEP+1)'(1);
  localparam logic [LOG_DEP-1:0] PTR_ONE = LOG_DEP'(1);

  // Maximal-length tap sets (bit positions, MSB always included) per width.
  function automatic logic [15:0] tap_mask(input int n);
    case (n)
      2:       tap_mask = 16'h0003;
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]        TAP_ALL = tap_mask(LOG_DEP);
  localparam logic [LOG_DEP-1:0] TAPS    = TAP_ALL[LOG_DEP-1:0];

  // Inverting feedback when the low bits are all zero splices state 0 into
  // the cycle (100..0 -> 0 -> 1), giving a period of exactly DEPTH.
  function automatic logic [LOG_DEP-1:0] succ(input logic [LOG_DEP-1:0] x);
    logic fb;
    fb = 1'b0;
    if (ADDR_MODE == 0) begin
      succ = x + PTR_ONE;
    end else begin
      fb   = (^(x & TAPS)) ^ (x[LOG_DEP-2:0] == '0);
      succ = {x[LOG_DEP-2:0], fb};
    end
  endfunction

  logic [LOG_DEP-1:0] head_reg, tail_reg;
  logic [LOG_DEP:0]   count_reg, count_next;
  logic               overflow_reg, underflow_reg;
  logic               full_int, empty_int;
  logic               vw, vr;

  assign full_int  = (count_reg == DEPTH_CNT);
  assign empty_int = (count_reg == '0);

  // A read frees a slot in the same cycle, so a full FIFO still accepts read+write.
  always_comb begin
    vr = enable & read & ~empty_int & ~flush;
    vw = enable & write & (~full_int | read) & ~flush;
  end

  always_comb begin
    count_next = count_reg;
    case ({vw, vr})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (vw) tail_reg <= succ(tail_reg);
      if (vr) head_reg <= succ(head_reg);
      count_reg <= count_next;
      if (enable & write & ~vw) overflow_reg  <= 1'b1;
      if (enable & read & ~vr)  underflow_reg <= 1'b1;
    end
  end

  assign full           = full_int;
  assign empty          = empty_int;
  assign almost_full    = (count_reg >= AF_LEVEL);
  assign almost_empty   = (count_reg <= AE_LEVEL);
  assign count          = count_reg;
  assign overflow       = overflow_reg;
  assign underflow      = underflow_reg;
  assign ram_wen        = vw;
  assign ram_waddr      = tail_reg;
  assign ram_raddr      = head_reg;
  assign ram_raddr_next = succ(head_reg);

endmodule

// File: tb/tb_ramfifo_ctrl_gen2.sv
// Directed bench: instance A (depth 8, LFSR, AF=2, AE=1) and instance B (depth 8, binary)
// with a small RAM model to confirm data ordering across wrap.
module tb_ramfifo_ctrl_gen2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic       a_enable, a_flush, a_write, a_read;
  logic       a_full, a_empty, a_af, a_ae, a_overflow, a_underflow, a_wen;
  logic [3:0] a_count;
  logic [2:0] a_waddr, a_raddr, a_rnext;

  logic       b_enable, b_flush, b_write, b_read;
  logic       b_full, b_empty, b_af, b_ae, b_overflow, b_underflow, b_wen;
  logic [3:0] b_count;
  logic [2:0] b_waddr, b_raddr, b_rnext;
  logic [7:0] b_wdata;
  logic [7:0] mem [8];

  int check_count = 0;
  int error_count = 0;

  // Zero-inclusive LFSR order for width 3, taps at bits 2 and 1, worked by hand.
  logic [2:0] lfsr_seq [8] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};

  ramfifo_ctrl_gen2 #(.LOG_DEP(3), .ADDR_MODE(1), .AF_MARGIN(2), .AE_MARGIN(1)) dut_a (
    .clock(clock), .reset(reset), .enable(a_enable), .flush(a_flush),
    .write(a_write), .read(a_read), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_overflow), .underflow(a_underflow), .ram_wen(a_wen),
    .ram_waddr(a_waddr), .ram_raddr(a_raddr), .ram_raddr_next(a_rnext)
  );

  ramfifo_ctrl_gen2 #(.LOG_DEP(3), .ADDR_MODE(0), .AF_MARGIN(4), .AE_MARGIN(4)) dut_b (
    .clock(clock), .reset(reset), .enable(b_enable), .flush(b_flush),
    .write(b_write), .read(b_read), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_overflow), .underflow(b_underflow), .ram_wen(b_wen),
    .ram_waddr(b_waddr), .ram_raddr(b_raddr), .ram_raddr_next(b_rnext)
  );

  always @(posedge clock) begin
    if (b_wen) mem[b_waddr] <= b_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic a_set(input logic en, input logic fl, input logic wr, input logic rd);
    a_enable = en; a_flush = fl; a_write = wr; a_read = rd;
    #1;
    $display("A en=%0b fl=%0b wr=%0b rd=%0b wen=%0b waddr=%0d raddr=%0d count=%0d",
             en, fl, wr, rd, a_wen, a_waddr, a_raddr, a_count);
  endtask

  task automatic b_set(input logic en, input logic fl, input logic wr, input logic rd);
    b_enable = en; b_flush = fl; b_write = wr; b_read = rd;
    #1;
    $display("B en=%0b wr=%0b rd=%0b wen=%0b waddr=%0d raddr=%0d data=%0d count=%0d",
             en, wr, rd, b_wen, b_waddr, b_raddr, b_wdata, b_count);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    reset = 1'b1;
    a_enable = 0; a_flush = 0; a_write = 0; a_read = 0;
    b_enable = 0; b_flush = 0; b_write = 0; b_read = 0; b_wdata = 8'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    check("rst_empty", 32'(a_empty), 1);
    check("rst_full", 32'(a_full), 0);
    check("rst_ae", 32'(a_ae), 1);
    check("rst_af", 32'(a_af), 0);
    check("rst_count", 32'(a_count), 0);
    check("rst_ovf", 32'(a_overflow), 0);
    check("rst_unf", 32'(a_underflow), 0);
    check("rst_wen", 32'(a_wen), 0);
    check("rst_waddr", 32'(a_waddr), 0);
    check("rst_raddr", 32'(a_raddr), 0);
    check("rst_rnext", 32'(a_rnext), 1);

    // enable low: nothing moves, no errors
    a_set(0, 0, 1, 1);
    check("enlow_wen", 32'(a_wen), 0);
    tick();
    check("enlow_count", 32'(a_count), 0);
    check("enlow_waddr", 32'(a_waddr), 0);
    check("enlow_unf", 32'(a_underflow), 0);
    check("enlow_ovf", 32'(a_overflow), 0);

    // fill 8 entries: LFSR address order and flag thresholds
    for (int i = 0; i < 8; i++) begin
      a_set(1, 0, 1, 0);
      check("fill_wen", 32'(a_wen), 1);
      check("fill_waddr", 32'(a_waddr), 32'(lfsr_seq[i]));
      tick();
      check("fill_count", 32'(a_count), 32'(i + 1));
      check("fill_af", 32'(a_af), 32'((i + 1) >= 6));
      check("fill_ae", 32'(a_ae), 32'((i + 1) <= 1));
      check("fill_full", 32'(a_full), 32'(i == 7));
      check("fill_empty", 32'(a_empty), 0);
    end

    // write into a full FIFO is refused
    a_set(1, 0, 1, 0);
    check("ovf_wen", 32'(a_wen), 0);
    tick();
    check("ovf_flag", 32'(a_overflow), 1);
    check("ovf_count", 32'(a_count), 8);
    check("ovf_waddr", 32'(a_waddr), 0);

    // drain: read order matches write order
    for (int i = 0; i < 8; i++) begin
      a_set(1, 0, 0, 1);
      check("drain_wen", 32'(a_wen), 0);
      check("drain_raddr", 32'(a_raddr), 32'(lfsr_seq[i]));
      check("drain_rnext", 32'(a_rnext), 32'(lfsr_seq[(i + 1) % 8]));
      tick();
      check("drain_count", 32'(a_count), 32'(7 - i));
      check("drain_empty", 32'(a_empty), 32'(i == 7));
    end

    // read of an empty FIFO is refused
    a_set(1, 0, 0, 1);
    tick();
    check("unf_flag", 32'(a_underflow), 1);
    check("unf_raddr", 32'(a_raddr), 0);
    check("unf_count", 32'(a_count), 0);

    // flush with enable low still clears sticky errors
    a_set(0, 1, 0, 0);
    tick();
    check("flush_ovf", 32'(a_overflow), 0);
    check("flush_unf", 32'(a_underflow), 0);

    // empty FIFO, read+write together: write wins, read refused
    a_set(1, 0, 1, 1);
    check("rwe_wen", 32'(a_wen), 1);
    check("rwe_waddr", 32'(a_waddr), 0);
    tick();
    check("rwe_count", 32'(a_count), 1);
    check("rwe_unf", 32'(a_underflow), 1);
    check("rwe_raddr", 32'(a_raddr), 0);
    check("rwe_waddr_next", 32'(a_waddr), 1);

    for (int i = 1; i < 8; i++) begin
      a_set(1, 0, 1, 0);
      check("refill_waddr", 32'(a_waddr), 32'(lfsr_seq[i]));
      tick();
    end
    check("refill_full", 32'(a_full), 1);

    // full FIFO, read+write together: both pointers advance
    a_set(1, 0, 1, 1);
    check("rwf_wen", 32'(a_wen), 1);
    check("rwf_waddr", 32'(a_waddr), 0);
    check("rwf_raddr", 32'(a_raddr), 0);
    tick();
    check("rwf_count", 32'(a_count), 8);
    check("rwf_full", 32'(a_full), 1);
    check("rwf_waddr_next", 32'(a_waddr), 1);
    check("rwf_raddr_next", 32'(a_raddr), 1);
    check("rwf_ovf", 32'(a_overflow), 0);

    a_set(1, 0, 1, 0);
    tick();
    check("ovf2_flag", 32'(a_overflow), 1);
    for (int i = 1; i < 4; i++) begin
      a_set(1, 0, 0, 1);
      check("pre_flush_raddr", 32'(a_raddr), 32'(lfsr_seq[i]));
      tick();
    end
    check("pre_flush_count", 32'(a_count), 5);

    // flush beats a simultaneous write
    a_set(1, 1, 1, 0);
    check("flush_wen", 32'(a_wen), 0);
    tick();
    check("flush_count", 32'(a_count), 0);
    check("flush_waddr", 32'(a_waddr), 0);
    check("flush_raddr", 32'(a_raddr), 0);
    check("flush_rnext", 32'(a_rnext), 1);
    check("flush_ovf2", 32'(a_overflow), 0);
    check("flush_empty", 32'(a_empty), 1);

    // reset mid-operation: next write lands at address 0
    a_set(1, 0, 1, 0);
    tick();
    a_set(1, 0, 1, 0);
    tick();
    check("mid_count", 32'(a_count), 2);
    check("mid_waddr", 32'(a_waddr), 2);
    reset = 1'b1;
    a_set(0, 0, 0, 0);
    tick();
    reset = 1'b0;
    check("mid_rst_count", 32'(a_count), 0);
    a_set(1, 0, 1, 0);
    check("mid_rst_waddr", 32'(a_waddr), 0);
    tick();
    check("mid_rst_count1", 32'(a_count), 1);
    a_set(0, 0, 0, 0);

    // binary mode wrap with interleaved reads and data ordering
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      logic wr, rd;
      wr = (i < 10);
      rd = (i >= 2);
      b_wdata = 8'(i);
      b_set(1, 0, wr, rd);
      if (wr) begin
        check("bin_wen", 32'(b_wen), 1);
        check("bin_waddr", 32'(b_waddr), 32'(i % 8));
      end
      if (rd) begin
        check("bin_raddr", 32'(b_raddr), 32'((i - 2) % 8));
        check("bin_data", 32'(mem[b_raddr]), 32'(i - 2));
      end
      tick();
      nb = nb + (wr ? 1 : 0) - (rd ? 1 : 0);
      check("bin_count", 32'(b_count), 32'(nb));
    end
    b_set(0, 0, 0, 0);
    check("bin_empty", 32'(b_empty), 1);
    check("bin_ae", 32'(b_ae), 1);
    check("bin_unf", 32'(b_underflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
